// File: rtl/digit_classifier_pkg.sv
// Shared types, feature-code layout and code-to-digit lookup for digit_feature_classifier.
package digit_classifier_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DECIDE = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Feature code layout {vcnt[1:0], l1, r1, l2, r2}; horizontal segment indices match bit positions.
    localparam int unsigned FC_W    = 6;
    localparam int unsigned FC_R2   = 0;
    localparam int unsigned FC_L2   = 1;
    localparam int unsigned FC_R1   = 2;
    localparam int unsigned FC_L1   = 3;
    localparam int unsigned SEG_V   = 4;
    localparam int unsigned NUM_SEG = 5;

    localparam logic [3:0] DIGIT_NONE = 4'hF;

    function automatic logic [3:0] code_to_digit(input logic [FC_W-1:0] code);
        logic [3:0] digit;
        digit = DIGIT_NONE;
        case (code)
            6'b10_1111: digit = 4'd0;
            6'b01_1010: digit = 4'd1;
            6'b01_0101: digit = 4'd1;
            6'b11_0110: digit = 4'd2;
            6'b11_0101: digit = 4'd3;
            6'b10_1110: digit = 4'd4;
            6'b11_1001: digit = 4'd5;
            6'b11_1011: digit = 4'd6;
            6'b10_0110: digit = 4'd7;
            6'b11_1111: digit = 4'd8;
            6'b11_1101: digit = 4'd9;
            default:    digit = DIGIT_NONE;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/digit_feature_classifier_crossing_detector.sv
// Per-segment background-to-stroke crossing detector with its own pixel history.
// DIGIT_MINRUN_EN: a crossing needs background, stroke, stroke (run of >= 2 stroke pixels).
module crossing_detector (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hit,
    input  logic pix,
    output logic cross_c
);

`ifdef DIGIT_MINRUN_EN
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= 2'b00;
        end else if (hit) begin
            hist <= {hist[0], pix};
        end
    end

    assign cross_c = hit && pix && (hist == 2'b01);
`else
    logic prev;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev <= 1'b0;
        end else if (hit) begin
            prev <= pix;
        end
    end

    assign cross_c = hit && pix && !prev;
`endif

endmodule

// File: rtl/digit_feature_classifier.sv
// Streaming crossing-feature digit classifier: scan-line crossing features, lookup, frame debounce.
// Optional macro DIGIT_MINRUN_EN selects the 2-pixel minimum-run crossing rule in crossing_detector.
module digit_feature_classifier
    import digit_classifier_pkg::*;
#(
    parameter int unsigned COORD_W       = 10,
    parameter int unsigned ROW1_NUM      = 2,
    parameter int unsigned ROW1_DEN      = 5,
    parameter int unsigned ROW2_NUM      = 2,
    parameter int unsigned ROW2_DEN      = 3,
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned SC_W          = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iFrameStart,
    input  logic                 iFrameEnd,
    input  logic [2*COORD_W-1:0] iEdge_Row,
    input  logic [2*COORD_W-1:0] iEdge_Col,
    input  logic [COORD_W-1:0]   iRow,
    input  logic [COORD_W-1:0]   iCol,
    input  logic                 iPix,
    output logic [FC_W-1:0]      oRecognition,
    output logic                 oFrameDone,
    output logic [3:0]           oDigital,
    output logic                 oUpdate
);

    localparam int unsigned AW = COORD_W + 3;
    localparam logic [SC_W-1:0] STABLE_MAX = SC_W'(STABLE_FRAMES);

    state_t             state;
    logic [COORD_W-1:0] top, bottom, left, right;
    logic [COORD_W-1:0] y_col, x1_row, x2_row;
    logic               degen;
    logic [1:0]         vcnt;
    logic [3:0]         hflags;
    logic [3:0]         frame_digit, candidate;
    logic [SC_W-1:0]    stable_cnt;

    logic [COORD_W-1:0] e_top_c, e_bot_c, e_left_c, e_right_c;
    logic [COORD_W-1:0] y_c, x1_c, x2_c;
    logic               start_c, scan_c, in_left_c, in_right_c;
    logic [NUM_SEG-1:0] hit_c, cross_c;
    logic [FC_W-1:0]    code_c;
    logic [3:0]         cand_next_c;
    logic [SC_W-1:0]    cnt_next_c;

    assign e_top_c   = iEdge_Row[COORD_W-1:0];
    assign e_bot_c   = iEdge_Row[2*COORD_W-1:COORD_W];
    assign e_left_c  = iEdge_Col[COORD_W-1:0];
    assign e_right_c = iEdge_Col[2*COORD_W-1:COORD_W];

    // Scan-line geometry computed in AW bits, truncated back to pixel coordinates.
    assign y_c  = COORD_W'((AW'(e_left_c) + AW'(e_right_c)) >> 1);
    assign x1_c = COORD_W'(AW'(e_top_c)
                  + (AW'(e_bot_c) - AW'(e_top_c)) * AW'(ROW1_NUM) / AW'(ROW1_DEN));
    assign x2_c = COORD_W'(AW'(e_top_c)
                  + (AW'(e_bot_c) - AW'(e_top_c)) * AW'(ROW2_NUM) / AW'(ROW2_DEN));

    assign start_c    = iFrameStart && ((state == IDLE) || (state == SCAN));
    assign scan_c     = (state == SCAN) && en && !iFrameStart && !degen;
    assign in_left_c  = (iCol > left) && (iCol < y_col);
    assign in_right_c = (iCol > y_col) && (iCol < right);

    always_comb begin
        hit_c        = '0;
        hit_c[SEG_V] = scan_c && (iCol == y_col) && (iRow > top) && (iRow < bottom);
        hit_c[FC_L1] = scan_c && (iRow == x1_row) && in_left_c;
        hit_c[FC_R1] = scan_c && (iRow == x1_row) && in_right_c;
        hit_c[FC_L2] = scan_c && (iRow == x2_row) && in_left_c;
        hit_c[FC_R2] = scan_c && (iRow == x2_row) && in_right_c;
    end

    for (genvar s = 0; s < NUM_SEG; s++) begin : g_seg
        crossing_detector u_det (
            .clk     (clk),
            .rst     (rst),
            .clr     (start_c),
            .hit     (hit_c[s]),
            .pix     (iPix),
            .cross_c (cross_c[s])
        );
    end

    assign code_c = {vcnt, hflags};

    // Debounce: a repeat of the candidate counts up, anything else restarts the run.
    always_comb begin
        cand_next_c = candidate;
        cnt_next_c  = stable_cnt;
        if (frame_digit == candidate) begin
            if (stable_cnt < STABLE_MAX) begin
                cnt_next_c = stable_cnt + SC_W'(1);
            end
        end else begin
            cand_next_c = frame_digit;
            cnt_next_c  = SC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            top          <= '0;
            bottom       <= '0;
            left         <= '0;
            right        <= '0;
            y_col        <= '0;
            x1_row       <= '0;
            x2_row       <= '0;
            degen        <= 1'b0;
            vcnt         <= '0;
            hflags       <= '0;
            frame_digit  <= DIGIT_NONE;
            candidate    <= DIGIT_NONE;
            stable_cnt   <= '0;
            oRecognition <= '0;
            oFrameDone   <= 1'b0;
            oDigital     <= DIGIT_NONE;
            oUpdate      <= 1'b0;
        end else begin
            oFrameDone <= 1'b0;
            oUpdate    <= 1'b0;
            if (start_c) begin
                top    <= e_top_c;
                bottom <= e_bot_c;
                left   <= e_left_c;
                right  <= e_right_c;
                y_col  <= y_c;
                x1_row <= x1_c;
                x2_row <= x2_c;
                degen  <= (e_bot_c <= e_top_c) || (e_right_c <= e_left_c);
                vcnt   <= '0;
                hflags <= '0;
                state  <= SCAN;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    SCAN: begin
                        if (cross_c[SEG_V] && (vcnt != 2'd3)) begin
                            vcnt <= vcnt + 2'd1;
                        end
                        hflags <= hflags | cross_c[3:0];
                        if (iFrameEnd) begin
                            state <= DECIDE;
                        end
                    end
                    DECIDE: begin
                        oRecognition <= code_c;
                        oFrameDone   <= 1'b1;
                        frame_digit  <= code_to_digit(code_c);
                        state        <= COMMIT;
                    end
                    COMMIT: begin
                        candidate  <= cand_next_c;
                        stable_cnt <= cnt_next_c;
                        if ((cnt_next_c >= STABLE_MAX) && (cand_next_c != oDigital)) begin
                            oDigital <= cand_next_c;
                            oUpdate  <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_digit_feature_classifier.sv
// Scoreboard bench for digit_feature_classifier: random sparse frames against a run-counting feature model.
module tb_digit_feature_classifier;

    localparam int SF  = 3;
    localparam int R1N = 2;
    localparam int R1D = 5;
    localparam int R2N = 2;
    localparam int R2D = 3;
`ifdef DIGIT_MINRUN_EN
    localparam int MINLEN = 2;
`else
    localparam int MINLEN = 1;
`endif

    localparam logic [5:0] DIG_CODE [10] = '{
        6'b10_1111, 6'b01_1010, 6'b11_0110, 6'b11_0101, 6'b10_1110,
        6'b11_1001, 6'b11_1011, 6'b10_0110, 6'b11_1111, 6'b11_1101
    };

    logic        clk = 1'b0;
    logic        rst, en, fs, fe, pix;
    logic [19:0] erow, ecol;
    logic [9:0]  row, col;
    logic [5:0]  rec;
    logic        done, upd;
    logic [3:0]  digital;

    always #5 clk = ~clk;

    digit_feature_classifier dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .iFrameStart  (fs),
        .iFrameEnd    (fe),
        .iEdge_Row    (erow),
        .iEdge_Col    (ecol),
        .iRow         (row),
        .iCol         (col),
        .iPix         (pix),
        .oRecognition (rec),
        .oFrameDone   (done),
        .oDigital     (digital),
        .oUpdate      (upd)
    );

    typedef struct {
        logic [5:0] code;
        logic       upd;
        logic [3:0] dig;
    } exp_t;

    typedef struct {
        int row;
        int col;
        bit pix;
    } px_t;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    bit   vpat [1024];
    bit   h1pat[1024];
    bit   h2pat[1024];

    logic [3:0] m_cand, m_dig;
    int         m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] lut(input logic [5:0] code);
        if (code == 6'b01_0101) return 4'd1;
        for (int d = 0; d < 10; d++) begin
            if (DIG_CODE[d] == code) return 4'(d);
        end
        return 4'hF;
    endfunction

    // Number of stroke runs of at least MINLEN pixels inside [lo, hi].
    function automatic int count_runs(input int sel, input int lo, input int hi);
        int n = 0;
        int len = 0;
        bit p;
        for (int i = lo; i <= hi; i++) begin
            p = (sel == 0) ? vpat[i] : (sel == 1) ? h1pat[i] : h2pat[i];
            if (p) len++;
            else begin
                if (len >= MINLEN) n++;
                len = 0;
            end
        end
        if (len >= MINLEN) n++;
        return n;
    endfunction

    function automatic logic [5:0] model_code(input int t, input int b, input int l, input int r);
        int y, x1, x2, v;
        if (b <= t || r <= l) return 6'b0;
        y  = (l + r) / 2;
        x1 = t + (b - t) * R1N / R1D;
        x2 = t + (b - t) * R2N / R2D;
        v  = count_runs(0, t + 1, b - 1);
        if (v > 3) v = 3;
        return {2'(v), count_runs(1, l + 1, y - 1) > 0, count_runs(1, y + 1, r - 1) > 0,
                count_runs(2, l + 1, y - 1) > 0, count_runs(2, y + 1, r - 1) > 0};
    endfunction

    task automatic model_reset();
        m_cand = 4'hF;
        m_cnt  = 0;
        m_dig  = 4'hF;
    endtask

    task automatic push_expect(input logic [5:0] code);
        logic [3:0] fd;
        logic       u;
        fd = lut(code);
        if (fd == m_cand) begin
            if (m_cnt < SF) m_cnt++;
        end else begin
            m_cand = fd;
            m_cnt  = 1;
        end
        u = (m_cnt >= SF) && (m_cand != m_dig);
        if (u) m_dig = m_cand;
        sb.push_back('{code, u, m_dig});
    endtask

    task automatic set_pat(input int sel, input int i, input bit v);
        case (sel)
            0:       vpat[i]  = v;
            1:       h1pat[i] = v;
            default: h2pat[i] = v;
        endcase
    endtask

    task automatic place_runs(input int sel, input int lo, input int hi, input int n, input int runlen);
        int p;
        p = lo + int'($urandom_range(0, 1));
        repeat (n) begin
            for (int k = 0; k < runlen; k++) begin
                if (p + k <= hi) set_pat(sel, p + k, 1'b1);
            end
            p += runlen + int'($urandom_range(1, 3));
        end
    endtask

    // mode 0: clean runs, 1: add isolated single strokes on L1, 2: random bits everywhere
    task automatic gen(input int t, input int b, input int l, input int r,
                       input int vn, input logic [3:0] flags, input int mode);
        int y, rl;
        y = (l + r) / 2;
        for (int i = 0; i < 1024; i++) begin
            vpat[i] = 1'b0; h1pat[i] = 1'b0; h2pat[i] = 1'b0;
        end
        vpat[t] = 1'b1; vpat[b] = 1'b1;
        h1pat[l] = 1'b1; h1pat[r] = 1'b1; h2pat[l] = 1'b1; h2pat[r] = 1'b1;
        if (mode == 2) begin
            for (int i = t + 1; i < b; i++) vpat[i] = ($urandom_range(0, 2) == 0);
            for (int c = l + 1; c < r; c++) begin
                h1pat[c] = ($urandom_range(0, 2) == 0);
                h2pat[c] = ($urandom_range(0, 2) == 0);
            end
        end else begin
            place_runs(0, t + 1, b - 1, vn, 2);
            rl = 2 + int'($urandom_range(0, 2));
            if (flags[3]) place_runs(1, l + 1, y - 1, 1, rl);
            if (flags[2]) place_runs(1, y + 1, r - 1, 1, rl);
            if (flags[1]) place_runs(2, l + 1, y - 1, 1, rl);
            if (flags[0]) place_runs(2, y + 1, r - 1, 1, rl);
            if (mode == 1) begin
                h1pat[l + 2] = 1'b1;
                h1pat[l + 5] = 1'b1;
            end
        end
    endtask

    // Streams a frame; cut >= 0 stops after that many pixels (abort, or reset if do_rst).
    task automatic run_frame(input int t, input int b, input int l, input int r,
                             input int cut, input bit do_rst);
        px_t q[$];
        int  y, x1, x2;
        bit  coincide;
        y  = (l + r) / 2;
        x1 = t + (b - t) * R1N / R1D;
        x2 = t + (b - t) * R2N / R2D;
        for (int rr = t; rr <= b; rr++) begin
            if (rr == x1 || rr == x2) begin
                for (int c = l; c <= r; c++)
                    q.push_back('{rr, c, (c == y) ? vpat[rr] : (rr == x1 ? h1pat[c] : h2pat[c])});
            end else begin
                q.push_back('{rr, y, vpat[rr]});
            end
        end
        fs = 1'b1; en = 1'b0; fe = 1'b0;
        erow = {10'(b), 10'(t)};
        ecol = {10'(r), 10'(l)};
        tick();
        fs = 1'b0;
        erow = 20'($urandom);
        ecol = 20'($urandom);
        coincide = 1'($urandom_range(0, 1));
        for (int i = 0; i < q.size(); i++) begin
            if (cut >= 0 && i == cut) break;
            if ($urandom_range(0, 7) == 0) begin
                en = 1'b0; row = 10'(q[i].row); col = 10'(q[i].col); pix = 1'b1;
                tick();
            end
            en  = 1'b1;
            row = 10'(q[i].row);
            col = 10'(q[i].col);
            pix = q[i].pix;
            fe  = coincide && (i == q.size() - 1) && (cut < 0);
            tick();
        end
        fe = 1'b0;
        if (cut >= 0) begin
            if (do_rst) begin
                en = 1'b0; rst = 1'b1;
                tick();
                rst = 1'b0;
                model_reset();
                tick();
            end
            return;
        end
        en = 1'b0;
        if (!coincide || q.size() == 0) begin
            fe = 1'b1;
            tick();
            fe = 1'b0;
        end
        push_expect(model_code(t, b, l, r));
        repeat (3) tick();
    endtask

    task automatic frame_code(input int t, input int b, input int l, input int r,
                              input logic [5:0] code, input int mode);
        gen(t, b, l, r, int'(code[5:4]), code[3:0], mode);
        run_frame(t, b, l, r, -1, 1'b0);
    endtask

    task automatic frame_digit(input int d);
        int t, b, l, r;
        logic [5:0] code;
        t = int'($urandom_range(0, 500));
        b = t + int'($urandom_range(40, 160));
        l = int'($urandom_range(0, 600));
        r = l + int'($urandom_range(20, 160));
        if (d == 1 && $urandom_range(0, 1) == 1) code = 6'b01_0101;
        else if (d < 10) code = DIG_CODE[d];
        else code = 6'b00_0011;
        if ($urandom_range(0, 4) == 0) gen(t, b, l, r, 0, 4'b0, 2);
        else gen(t, b, l, r, int'(code[5:4]), code[3:0], 0);
        run_frame(t, b, l, r, -1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    // Monitor: pops the scoreboard on every frame-done and checks the commit cycle after it.
    initial begin
        bit   pend;
        exp_t e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("update_pulse", 32'(upd), 32'(e.upd));
                check("digital", 32'(digital), 32'(e.dig));
                pend = 1'b0;
            end else if (upd === 1'b1) begin
                check("spurious_update", 32'(upd), 32'd0);
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("recognition", 32'(rec), 32'(e.code));
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, reps, wait_cnt;
        rst = 1'b1; en = 1'b0; fs = 1'b0; fe = 1'b0; pix = 1'b0;
        erow = '0; ecol = '0; row = '0; col = '0;
        model_reset();
        repeat (3) tick();
        check("rst_recognition", 32'(rec), 32'd0);
        check("rst_frame_done", 32'(done), 32'd0);
        check("rst_update", 32'(upd), 32'd0);
        check("rst_digital", 32'(digital), 32'hF);
        rst = 1'b0;
        tick();

        repeat (3) frame_code(100, 200, 50, 110, 6'b11_1111, 0);
        check("digit_after_three_8", 32'(digital), 32'd8);

        do_reset();
        frame_code(100, 200, 50, 110, 6'b01_1010, 0);
        frame_code(100, 200, 50, 110, 6'b01_1010, 0);
        frame_code(100, 200, 50, 110, 6'b10_0110, 0);
        check("digit_after_1_1_7", 32'(digital), 32'hF);
        frame_code(100, 200, 50, 110, 6'b10_0110, 0);
        check("digit_after_7_7", 32'(digital), 32'hF);
        frame_code(100, 200, 50, 110, 6'b10_0110, 0);
        check("digit_after_7_7_7", 32'(digital), 32'd7);

        gen(100, 200, 50, 110, 5, 4'b1111, 0);
        run_frame(100, 200, 50, 110, -1, 1'b0);

        gen(150, 150, 50, 110, 0, 4'b0, 2);
        run_frame(150, 150, 50, 110, -1, 1'b0);
        gen(100, 200, 110, 50, 0, 4'b0, 2);
        run_frame(100, 200, 110, 50, -1, 1'b0);

        do_reset();
        frame_code(100, 200, 50, 110, 6'b11_0101, 0);
        frame_code(100, 200, 50, 110, 6'b11_0101, 0);
        gen(100, 200, 50, 110, 3, 4'b0101, 0);
        run_frame(100, 200, 50, 110, 40, 1'b1);
        check("rst_mid_scan_digital", 32'(digital), 32'hF);
        check("rst_mid_scan_recognition", 32'(rec), 32'd0);
        frame_code(100, 200, 50, 110, 6'b11_0101, 0);
        frame_code(100, 200, 50, 110, 6'b11_0101, 0);
        check("digit_after_reset_two_3", 32'(digital), 32'hF);
        frame_code(100, 200, 50, 110, 6'b11_0101, 0);
        check("digit_after_reset_three_3", 32'(digital), 32'd3);

        gen(120, 220, 60, 130, 3, 4'b1001, 0);
        run_frame(120, 220, 60, 130, 30, 1'b0);
        frame_code(120, 220, 60, 130, 6'b11_1101, 0);

        frame_code(100, 200, 50, 110, 6'b10_0111, 1);

        for (int k = 0; k < 14; k++) begin
            d    = int'($urandom_range(0, 10));
            reps = int'($urandom_range(1, 4));
            repeat (reps) frame_digit(d);
        end

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 50) begin
            tick();
            wait_cnt++;
        end
        repeat (2) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
